// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: round-robin scan scheduler for a multiplexed hex display with enable mask, leading-zero blanking and freeze.
module hex_scan_ctrl #(
  parameter int CLK_DIV  = 250000,
  parameter int N_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] en_mask,
  input  logic       lz_blank,
  input  logic       freeze,
  output logic [2:0] an,
  output logic [3:0] hexplay_data,
  output logic       blank,
  output logic       tick
);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0] cnt;
  logic [2:0]    slot, slot_nxt;
  logic [3:0]    digit [8];
  logic [7:0]    tail_zero;
  logic          wrap, blank_c;
  assign wrap = !freeze && cnt == PW'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      slot <= '0;
      tick <= 1'b0;
      for (int i = 0; i < 8; i++) digit[i] <= '0;
    end else begin
      cnt  <= freeze ? cnt : wrap ? '0 : cnt + PW'(1);
      tick <= wrap;
      if (wrap) slot <= slot_nxt;
      if (wr_en && {1'b0, wr_addr} < 4'(N_DIGITS)) digit[wr_addr] <= wr_data;
    end
  end
  // Nearest enabled digit after slot, wrapping; falls back to holding slot.
  always_comb begin
    logic [3:0] s;
    slot_nxt = slot;
    s = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      s = {1'b0, slot} + 4'(k);
      s = (s >= 4'(N_DIGITS)) ? s - 4'(N_DIGITS) : s;
      if (en_mask[s[2:0]]) slot_nxt = s[2:0];
    end
  end
  // tail_zero[i]: digits i..N_DIGITS-1 are all zero.
  always_comb begin
    logic z;
    z = 1'b1;
    tail_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      z = z & (digit[i] == 4'h0);
      tail_zero[i] = z;
    end
  end
  assign blank_c = ~en_mask[slot] | (lz_blank & (slot != 3'd0) & tail_zero[slot]);
  always_ff @(posedge clk) begin
    an           <= rst ? 3'd0 : slot;
    blank        <= rst ? 1'b0 : blank_c;
    hexplay_data <= (rst || blank_c) ? 4'h0 : digit[slot];
  end
endmodule
